// File: rtl/uas_acc_seq_if.sv
// uas_acc_seq_if
//   Bundles the command handshake and the uas operand/result bus used by
//   uas_acc_seq.
//   slave  : the accumulator controller (accepts commands, drives A/B/M,
//            consumes S/C4/V).
//   master : the command sender together with the uas adder/subtractor.
//   Signals:
//     in_valid/in_ready  command handshake
//     in_op, in_b        0 = add, 1 = subtract; 4-bit operand B
//     in_clr             clear command (overrides in_op/in_b)
//     out_valid          one-cycle completion pulse
//     uas_a/uas_b/uas_m  operands and mode toward uas
//     uas_s/uas_c4/uas_v sum, carry-out and signed overflow from uas
interface uas_acc_seq_if;
   logic       in_valid;
   logic       in_ready;
   logic       in_op;
   logic [3:0] in_b;
   logic       in_clr;
   logic       out_valid;
   logic [3:0] uas_a;
   logic [3:0] uas_b;
   logic       uas_m;
   logic [3:0] uas_s;
   logic       uas_c4;
   logic       uas_v;

   modport slave (
      input  in_valid, in_op, in_b, in_clr, uas_s, uas_c4, uas_v,
      output in_ready, out_valid, uas_a, uas_b, uas_m
   );

   modport master (
      output in_valid, in_op, in_b, in_clr, uas_s, uas_c4, uas_v,
      input  in_ready, out_valid, uas_a, uas_b, uas_m
   );
endinterface

// File: rtl/uas_acc_seq.sv
// uas_acc_seq
//   Sequential accumulator controller wrapped around the combinational 4-bit
//   adder/subtractor uas. A command (add, subtract or clear) is accepted over
//   a valid/ready handshake. Add/sub commands register the operand and mode
//   onto the uas B/M inputs, let uas settle for one cycle, then commit S/C4/V
//   into the accumulator, carry flag and sticky overflow flag.
//   Ports:
//     clk, rst_n   clock (rising edge), asynchronous active-low reset
//     bus          uas_acc_seq_if.slave (handshake + uas bus)
//     acc          accumulator (also driven onto uas A)
//     acc_c        C4 of the last committed op (subtract: 1 = no borrow)
//     ovf_sticky   set by any committed op with V=1
//     op_count     committed add/sub count, saturating at CNT_MAX
//   Configuration macro:
//     UAS_ACC_SAT_EN  when defined, an overflowing commit loads the signed
//                     saturation limit toward the old accumulator sign
//                     instead of the wrapped sum.
module uas_acc_seq #(
   parameter logic [3:0] CNT_MAX = 4'd15
) (
   input  logic               clk,
   input  logic               rst_n,
   uas_acc_seq_if.slave       bus,
   output logic [3:0]         acc,
   output logic               acc_c,
   output logic               ovf_sticky,
   output logic [3:0]         op_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_r;
   logic [3:0] acc_r;
   logic       acc_c_r;
   logic       ovf_r;
   logic [3:0] cnt_r;
   logic [3:0] b_r;
   logic       m_r;
   logic       in_ready_r;
   logic       out_valid_r;

   logic [3:0] acc_nxt_s;
   logic [3:0] cnt_nxt_s;

   // Value the accumulator takes on an EXEC commit.
   always_comb begin
      acc_nxt_s = bus.uas_s;
`ifdef UAS_ACC_SAT_EN
      // On overflow the true result lies beyond the limit on the side of
      // the old accumulator sign, so clamp toward that sign.
      if (bus.uas_v) begin
         acc_nxt_s = acc_r[3] ? 4'b1000 : 4'b0111;
      end else begin
         acc_nxt_s = bus.uas_s;
      end
`endif
   end

   // Saturating increment of the committed-op counter.
   always_comb begin
      if (cnt_r < CNT_MAX) begin
         cnt_nxt_s = cnt_r + 4'd1;
      end else begin
         cnt_nxt_s = CNT_MAX;
      end
   end

   // Control FSM with registered handshake outputs and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         acc_r       <= 4'd0;
         acc_c_r     <= 1'b0;
         ovf_r       <= 1'b0;
         cnt_r       <= 4'd0;
         b_r         <= 4'd0;
         m_r         <= 1'b0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               // in_ready_r is low for the first cycle after reset release,
               // so acceptance is gated by the registered ready itself.
               if (bus.in_valid && in_ready_r) begin
                  in_ready_r <= 1'b0;
                  if (bus.in_clr) begin
                     acc_r       <= 4'd0;
                     acc_c_r     <= 1'b0;
                     ovf_r       <= 1'b0;
                     cnt_r       <= 4'd0;
                     out_valid_r <= 1'b1;
                     state_r     <= DONE;
                  end else begin
                     b_r     <= bus.in_b;
                     m_r     <= bus.in_op;
                     state_r <= EXEC;
                  end
               end else begin
                  in_ready_r <= 1'b1;
               end
            end
            EXEC: begin
               // uas has settled on acc/b_r/m_r during this cycle.
               acc_r       <= acc_nxt_s;
               acc_c_r     <= bus.uas_c4;
               ovf_r       <= ovf_r | bus.uas_v;
               cnt_r       <= cnt_nxt_s;
               out_valid_r <= 1'b1;
               state_r     <= DONE;
            end
            DONE: begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               state_r     <= IDLE;
            end
            default: begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.uas_a     = acc_r;
   assign bus.uas_b     = b_r;
   assign bus.uas_m     = m_r;
   assign acc           = acc_r;
   assign acc_c         = acc_c_r;
   assign ovf_sticky    = ovf_r;
   assign op_count      = cnt_r;

endmodule

// File: tb/tb_uas_acc_seq.sv
// tb_uas_acc_seq
//   Self-checking bench for uas_acc_seq. Contains a behavioural uas
//   (adder/subtractor) on the bus, a reference model of the accumulator
//   written in signed/unsigned integer arithmetic, a driver that pushes the
//   expected completion into a scoreboard queue at each accept, and a monitor
//   that pops and compares whenever out_valid is seen.
module tb_uas_acc_seq;

   logic clk;
   logic rst_n;
   logic [3:0] acc;
   logic acc_c;
   logic ovf_sticky;
   logic [3:0] op_count;

   uas_acc_seq_if ifc ();

   uas_acc_seq #(.CNT_MAX(4'd15)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (ifc),
      .acc        (acc),
      .acc_c      (acc_c),
      .ovf_sticky (ovf_sticky),
      .op_count   (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural uas: A + (M ? ~B : B) + M
   logic [3:0] bb;
   logic [4:0] sum;
   always_comb begin
      bb         = ifc.uas_m ? ~ifc.uas_b : ifc.uas_b;
      sum        = {1'b0, ifc.uas_a} + {1'b0, bb} + {4'b0000, ifc.uas_m};
      ifc.uas_s  = sum[3:0];
      ifc.uas_c4 = sum[4];
      ifc.uas_v  = (ifc.uas_a[3] == bb[3]) && (sum[3] != ifc.uas_a[3]);
   end

   typedef struct {
      int acc;
      int c;
      int ovf;
      int cnt;
      int b;
      int m;
      int cyc;
   } exp_t;

   exp_t q[$];
   int n_cmp = 0;
   int n_err = 0;
   int n_ov  = 0;
   int cyc   = 0;

   // reference model state
   int m_acc = 0, m_c = 0, m_ovf = 0, m_cnt = 0, m_b = 0, m_m = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int sgn4(input int u);
      return (u >= 8) ? u - 16 : u;
   endfunction

   task automatic model_apply(input bit clr, input bit op, input int b);
      int sa, sb, sr, ur, v;
      if (clr) begin
         m_acc = 0; m_c = 0; m_ovf = 0; m_cnt = 0;
      end else begin
         sa = sgn4(m_acc);
         sb = sgn4(b);
         if (!op) begin
            ur = m_acc + b;
            m_c = (ur > 15) ? 1 : 0;
            sr = sa + sb;
         end else begin
            ur = m_acc - b;
            m_c = (m_acc >= b) ? 1 : 0;
            sr = sa - sb;
         end
         v = (sr > 7 || sr < -8) ? 1 : 0;
         if (v != 0) m_ovf = 1;
`ifdef UAS_ACC_SAT_EN
         if (v != 0) m_acc = (sa < 0) ? 8 : 7;
         else        m_acc = ((ur % 16) + 16) % 16;
`else
         m_acc = ((ur % 16) + 16) % 16;
`endif
         m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
         m_b = b;
         m_m = op ? 1 : 0;
      end
   endtask

   // monitor: pop and compare on each completion pulse
   always @(negedge clk) begin
      if (rst_n && ifc.out_valid) begin
         exp_t e;
         n_ov++;
         if (q.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
         end else begin
            e = q.pop_front();
            chk("acc", int'(acc), e.acc);
            chk("uas_a", int'(ifc.uas_a), e.acc);
            chk("acc_c", int'(acc_c), e.c);
            chk("ovf_sticky", int'(ovf_sticky), e.ovf);
            chk("op_count", int'(op_count), e.cnt);
            chk("uas_b", int'(ifc.uas_b), e.b);
            chk("uas_m", int'(ifc.uas_m), e.m);
            chk("out_valid_cycle", cyc, e.cyc);
         end
      end
   end

   // issue one command; returns the cycle stamp of its accept
   task automatic send(input bit clr, input bit op, input int b, input bit hold,
                       output int acc_cyc);
      exp_t e;
      int budget;
      @(negedge clk);
      ifc.in_valid = 1'b1;
      ifc.in_clr   = clr;
      ifc.in_op    = op;
      ifc.in_b     = 4'(b);
      budget = 0;
      while (!ifc.in_ready && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      acc_cyc = cyc;
      if (!ifc.in_ready) begin
         chk("accept_timeout", 0, 1);
      end else begin
         model_apply(clr, op, b);
         e.acc = m_acc; e.c = m_c; e.ovf = m_ovf; e.cnt = m_cnt;
         e.b = m_b; e.m = m_m;
         e.cyc = cyc + (clr ? 1 : 2);
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      if (!hold) begin
         ifc.in_valid = 1'b0;
         ifc.in_op    = 1'($urandom);
         ifc.in_b     = 4'($urandom);
      end
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while (q.size() != 0 && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      chk("drain_queue", q.size(), 0);
      @(negedge clk);
      @(negedge clk);
   endtask

   int a0, a1, a2, ov0;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n        = 1'b0;
      ifc.in_valid = 1'b0;
      ifc.in_clr   = 1'b0;
      ifc.in_op    = 1'b0;
      ifc.in_b     = 4'd0;
      repeat (3) @(negedge clk);
      chk("rst_acc", int'(acc), 0);
      chk("rst_op_count", int'(op_count), 0);
      chk("rst_in_ready", int'(ifc.in_ready), 0);
      chk("rst_out_valid", int'(ifc.out_valid), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_release", int'(ifc.in_ready), 1);

      // add 1001 then 1010: wraps with overflow
      send(1'b1, 1'b0, 0, 1'b0, a0);
      send(1'b0, 1'b0, 9, 1'b0, a0);
      send(1'b0, 1'b0, 10, 1'b0, a0);
      drain();
`ifdef UAS_ACC_SAT_EN
      chk("plan1_acc", int'(acc), 8);
`else
      chk("plan1_acc", int'(acc), 3);
`endif
      chk("plan1_acc_c", int'(acc_c), 1);
      chk("plan1_ovf", int'(ovf_sticky), 1);

      // add 1001 then subtract 1010
      send(1'b1, 1'b0, 0, 1'b0, a0);
      send(1'b0, 1'b0, 9, 1'b0, a0);
      send(1'b0, 1'b1, 10, 1'b0, a0);
      drain();
      chk("plan2_acc", int'(acc), 15);
      chk("plan2_acc_c", int'(acc_c), 0);
      chk("plan2_ovf", int'(ovf_sticky), 0);
      chk("plan2_cnt", int'(op_count), 2);

      // in_valid held across three add-1 commands
      send(1'b1, 1'b0, 0, 1'b0, a0);
      drain();
      ov0 = n_ov;
      send(1'b0, 1'b0, 1, 1'b1, a0);
      send(1'b0, 1'b0, 1, 1'b1, a1);
      send(1'b0, 1'b0, 1, 1'b0, a2);
      drain();
      chk("held_spacing1", a1 - a0, 3);
      chk("held_spacing2", a2 - a1, 3);
      chk("held_acc", int'(acc), 3);
      chk("held_pulses", n_ov - ov0, 3);

      // op_count saturation
      send(1'b1, 1'b0, 0, 1'b0, a0);
      for (int i = 0; i < 17; i++) send(1'b0, 1'b0, 0, 1'b0, a0);
      drain();
      chk("sat_cnt", int'(op_count), 15);
      chk("sat_acc", int'(acc), 0);

      // overflow then clear
      send(1'b0, 1'b0, 7, 1'b0, a0);
      send(1'b0, 1'b0, 7, 1'b0, a0);
      drain();
      chk("pre_clear_ovf", int'(ovf_sticky), 1);
      send(1'b1, 1'b0, 0, 1'b0, a0);
      drain();
      chk("clear_ovf", int'(ovf_sticky), 0);
      chk("clear_cnt", int'(op_count), 0);

      // reset asserted during EXEC
      send(1'b0, 1'b0, 3, 1'b0, a0);
      send(1'b0, 1'b0, 5, 1'b0, a0);
      rst_n = 1'b0;
      #1;
      void'(q.pop_back());
      m_acc = 0; m_c = 0; m_ovf = 0; m_cnt = 0; m_b = 0; m_m = 0;
      chk("mid_rst_acc", int'(acc), 0);
      chk("mid_rst_cnt", int'(op_count), 0);
      chk("mid_rst_uas_b", int'(ifc.uas_b), 0);
      chk("mid_rst_out_valid", int'(ifc.out_valid), 0);
      chk("mid_rst_in_ready", int'(ifc.in_ready), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_ready_after", int'(ifc.in_ready), 1);
      chk("mid_rst_queue", q.size(), 0);

      // randomized commands
      for (int i = 0; i < 60; i++) begin
         send(($urandom_range(0, 7) == 0), 1'($urandom), int'($urandom_range(0, 15)),
              1'b0, a0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uas_acc_seq.md
# uas_acc_seq

Sequential accumulator controller that wraps the 4-bit adder/subtractor (`uas`). It accepts a stream of operand/op commands over a valid/ready handshake and drives the accumulator and the operand onto the `uas` A/B/M inputs. It captures S/C4/V back into the accumulator and a sticky overflow flag. It sits directly upstream and downstream of `uas`: it feeds its operands and consumes its result. Top-level wiring splits the 4-bit buses into `uas` bit ports (bit 0 = A0/B0/S0).

## Interface
- `CNT_MAX`, 15: saturation value of `op_count` (must fit in 4 bits).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: command valid.
- `in_ready` out 1: block can accept a command.
- `in_op` in 1: 0 = add, 1 = subtract (drives `uas` M).
- `in_b` in 4: operand B.
- `in_clr` in 1: clear command; overrides `in_op`/`in_b`.
- `uas_a` out 4: to `uas` A3..A0; always equals `acc`.
- `uas_b` out 4: to `uas` B3..B0; registered operand.
- `uas_m` out 1: to `uas` M; registered op.
- `uas_s` in 4: from `uas` S3..S0.
- `uas_c4` in 1: from `uas` C4.
- `uas_v` in 1: from `uas` V.
- `acc` out 4: accumulator.
- `acc_c` out 1: C4 of the last committed op. For subtract, 1 = no borrow.
- `ovf_sticky` out 1: set by any committed op with V=1.
- `op_count` out 4: committed add/sub count, saturating at `CNT_MAX`.
- `out_valid` out 1: one-cycle pulse when a command completes.

## Operation
- FSM states: IDLE, EXEC, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready` with `in_clr`=0: latch `in_b`→`uas_b`, `in_op`→`uas_m`; go to EXEC.
  - On `in_valid`&&`in_ready` with `in_clr`=1: at that edge, `acc`, `acc_c`, `ovf_sticky` and `op_count` clear to 0. `uas_b` and `uas_m` are unchanged. Go to DONE.
- **EXEC**
  - `in_ready`=0. `uas` settles combinationally during this cycle.
  - At the closing edge: `acc`←`uas_s`, `acc_c`←`uas_c4`, `ovf_sticky`←`ovf_sticky`|`uas_v`, `op_count`←min(`op_count`+1, `CNT_MAX`).
  - Go to DONE.
- **DONE**
  - `in_ready`=0, `out_valid`=1.
  - Unconditionally go to IDLE.
- Arithmetic is 4-bit two's complement, computed by `uas`.
  - Subtract = A + ~B + 1.
  - V = signed overflow. Without saturation, results wrap mod 16.
- Commands presented while `in_ready`=0 are held by the sender; they are not dropped and not consumed.
- `in_b`/`in_op` are sampled only at the accept edge; later changes have no effect.

## Timing
- All outputs reset to 0; state resets to IDLE. `in_ready`=1 one cycle after reset release.
- Add/sub command accepted at edge N:
  - `uas_b`/`uas_m` valid after N.
  - `acc` updated at N+1.
  - `out_valid` high for the cycle between N+1 and N+2.
  - `in_ready` returns at N+2.
- Clear accepted at edge N: `acc`=0 after N; `out_valid` high between N and N+1; `in_ready` returns at N+1.
- Throughput: one add/sub per 3 cycles, one clear per 2 cycles.
- `op_count` at `CNT_MAX` stays there; ops still execute normally.
- Reset asserted mid-EXEC or mid-DONE:
  - All registers clear immediately (async) and state returns to IDLE.
  - The in-flight op is discarded; no `out_valid` pulse.
- `ovf_sticky` clears only on reset or a clear command.

## Configuration
- Macro `UAS_ACC_SAT_EN`.
- Defined: on an EXEC commit with `uas_v`=1, `acc` loads a saturated value instead of `uas_s`.
  - Old `acc[3]`=0 → 4'b0111.
  - Old `acc[3]`=1 → 4'b1000.
  - `acc_c` and `ovf_sticky` update as normal.
- Undefined: `acc` always loads `uas_s` (wrap-around).

## Test plan
- Reset then clear; add `in_b`=4'b1001 (acc→1001); add 4'b1010 → `acc`=4'b0011, `acc_c`=1, `ovf_sticky`=1 (wrap build). With `UAS_ACC_SAT_EN`: `acc`=4'b1000.
- Clear; add 1001; subtract 1010 → `acc`=4'b1111, `acc_c`=0, `ovf_sticky`=0, `op_count`=2.
- Handshake: `in_valid` held high continuously with 3 add-1 commands → accepts spaced 3 cycles apart, `acc`=3, exactly 3 `out_valid` pulses.
- 17 consecutive add-0 commands → `op_count` saturates at 15, `acc` unchanged.
- Assert `rst_n`=0 during EXEC → all outputs 0 immediately, no `out_valid` pulse, `in_ready`=1 one cycle after release.
- Clear command after an overflow → `ovf_sticky`=0, `op_count`=0, `out_valid` pulse one cycle after accept.
